// File: rtl/wb_line_prefetch.sv
// Single-line read buffer with write-through between a Wishbone master and a slow Wishbone slave.
// Optional PREFETCH_CRIT_FIRST_EN: fill starts at the requested word and acks as soon as it arrives.
`timescale 1ns/1ps
module wb_line_prefetch #(
    parameter int LINE_WORDS = 4,
    parameter int LW_BITS    = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam int TAG_BITS = 30 - LW_BITS;
    localparam logic [LW_BITS-1:0] LAST_WORD = LW_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_t;

    state_t                state_q, state_d;
    logic [31:0]           line_q [LINE_WORDS];
    logic                  valid_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [TAG_BITS-1:0]   fill_tag_q;
    logic [LW_BITS-1:0]    req_idx_q;
    logic [LW_BITS-1:0]    fill_cnt_q;

    logic                  req;
    logic [TAG_BITS-1:0]   req_tag;
    logic [LW_BITS-1:0]    req_idx;
    logic                  rd_hit;
    logic                  m_done;
    logic                  fill_last;
    logic [LW_BITS-1:0]    first_idx;
    logic [LW_BITS-1:0]    fill_idx;
    logic                  wr_hit;
    logic [LW_BITS-1:0]    wr_idx;
    logic [31:0]           wr_word;

    // A request is only taken when no ack is showing, so a lingering strobe is never re-acked.
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign req_tag   = wbs_adr_i[31:LW_BITS+2];
    assign req_idx   = wbs_adr_i[LW_BITS+1:2];
    assign rd_hit    = valid_q && (tag_q == req_tag);
    assign m_done    = m_cyc_o & m_stb_o & m_ack_i;
    assign fill_last = (fill_cnt_q == LAST_WORD);
    assign wr_hit    = valid_q && (tag_q == m_adr_o[31:LW_BITS+2]);
    assign wr_idx    = m_adr_o[LW_BITS+1:2];

`ifdef PREFETCH_CRIT_FIRST_EN
    localparam bit CRIT_FIRST = 1'b1;
    assign first_idx = req_idx;
    assign fill_idx  = req_idx_q + fill_cnt_q;
`else
    localparam bit CRIT_FIRST = 1'b0;
    assign first_idx = '0;
    assign fill_idx  = fill_cnt_q;
`endif

    always_comb begin
        wr_word = line_q[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (m_sel_o[b]) wr_word[8*b +: 8] = m_dat_o[8*b +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wbs_we_i)     state_d = WRITE;
                    else if (!rd_hit) state_d = FILL;
                end
            end
            FILL:    if (m_done && fill_last) state_d = CRIT_FIRST ? IDLE : ACK;
            WRITE:   if (m_done) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line storage needs no reset: valid_q gates every use of it.
    always_ff @(posedge wb_clk_i) begin
        if (state_q == FILL && m_done) line_q[fill_idx] <= m_dat_i;
        else if (state_q == WRITE && m_done && wr_hit) line_q[wr_idx] <= wr_word;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            fill_tag_q <= '0;
            req_idx_q  <= '0;
            fill_cnt_q <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (wbs_we_i) begin
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b1;
                            m_sel_o <= wbs_sel_i;
                            m_adr_o <= wbs_adr_i;
                            m_dat_o <= wbs_dat_i;
                        end else if (rd_hit) begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= line_q[req_idx];
                        end else begin
                            valid_q    <= 1'b0;
                            fill_tag_q <= req_tag;
                            req_idx_q  <= req_idx;
                            fill_cnt_q <= '0;
                            m_cyc_o    <= 1'b1;
                            m_stb_o    <= 1'b1;
                            m_we_o     <= 1'b0;
                            m_sel_o    <= 4'hF;
                            m_adr_o    <= {req_tag, first_idx, 2'b00};
                        end
                    end
                end
                FILL: begin
                    if (m_done) begin
                        // Bus drops for one cycle after every word.
                        m_cyc_o    <= 1'b0;
                        m_stb_o    <= 1'b0;
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (CRIT_FIRST) begin
                            if (fill_cnt_q == '0) begin
                                wbs_ack_o <= wbs_cyc_i & wbs_stb_i;
                                wbs_dat_o <= m_dat_i;
                            end
                        end else if (fill_last) begin
                            wbs_ack_o <= wbs_cyc_i & wbs_stb_i;
                            wbs_dat_o <= (fill_idx == req_idx_q) ? m_dat_i : line_q[req_idx_q];
                        end
                        if (fill_last) begin
                            valid_q <= 1'b1;
                            tag_q   <= fill_tag_q;
                        end
                    end else if (!m_cyc_o) begin
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        m_adr_o <= {fill_tag_q, fill_idx, 2'b00};
                    end
                end
                WRITE: begin
                    if (m_done) begin
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        m_we_o    <= 1'b0;
                        wbs_ack_o <= wbs_cyc_i & wbs_stb_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_line_prefetch.sv
// Bench for wb_line_prefetch: directed table, reset-abort and stall sequences, random traffic vs a line model.
`timescale 1ns/1ps
module tb_wb_line_prefetch;

    localparam int LW     = 4;
    localparam int LWB    = 2;
    localparam int DELAYS = 10;
    localparam int HIT_LAT = 1;
    localparam int WR_LAT  = DELAYS + 1;
`ifdef PREFETCH_CRIT_FIRST_EN
    localparam bit CRIT     = 1'b1;
    localparam int MISS_LAT = DELAYS + 1;
`else
    localparam bit CRIT     = 1'b0;
    localparam int MISS_LAT = LW * (DELAYS + 1);
`endif

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    wb_line_prefetch #(.LINE_WORDS(LW), .LW_BITS(LWB)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .m_cyc_o  (m_cyc_o),
        .m_stb_o  (m_stb_o),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_ack_i  (m_ack_i),
        .m_dat_i  (m_dat_i)
    );

    // ---------------- clock / reset ----------------
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int cyc_n;
    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- downstream memory: ack on the DELAYS-th cycle of strobe ----------------
    logic [31:0] slv_mem [256];
    int          slv_cnt;
    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_ack_i <= 1'b0;
            m_dat_i <= '0;
            slv_cnt <= 0;
        end else if (m_cyc_o && m_stb_o && !m_ack_i) begin
            if (slv_cnt == DELAYS - 2) begin
                m_ack_i <= 1'b1;
                if (m_we_o) slv_mem[m_adr_o[9:2]] <= merge(slv_mem[m_adr_o[9:2]], m_dat_o, m_sel_o);
                else        m_dat_i <= slv_mem[m_adr_o[9:2]];
            end
            slv_cnt <= slv_cnt + 1;
        end else begin
            m_ack_i <= 1'b0;
            slv_cnt <= 0;
        end
    end

    // ---------------- downstream monitor ----------------
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        int          c;
    } xfer_t;
    xfer_t log_q[$];
    int    cyc_hi, min_gap, max_gap, last_ack_c, gap;
    logic  prev_stb = 1'b0;

    always @(negedge wb_clk_i) begin
        if (m_cyc_o) cyc_hi++;
        if (m_stb_o && !prev_stb && log_q.size() > 0) begin
            gap = cyc_n - last_ack_c - 1;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
        end
        if (m_cyc_o && m_stb_o && m_ack_i) begin
            log_q.push_back('{m_we_o, m_sel_o, m_adr_o, cyc_n});
            last_ack_c = cyc_n;
        end
        prev_stb = m_stb_o;
    end

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: one buffered line, memory image, expected downstream traffic.
    logic [31:0] ref_mem [256];
    bit          ref_valid;
    int          ref_line;

    task automatic model(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] exp_dat,
                         output int exp_lat, output int exp_n);
        int widx, line, first;
        widx = int'(adr[9:2]);
        line = int'(adr >> (LWB + 2));
        exp_dat = '0;
        if (we) begin
            ref_mem[widx] = merge(ref_mem[widx], dat, sel);
            exp_q.push_back({1'b1, sel, adr});
            exp_lat = WR_LAT;
            exp_n   = 1;
        end else begin
            exp_dat = ref_mem[widx];
            if (ref_valid && ref_line == line) begin
                exp_lat = HIT_LAT;
                exp_n   = 0;
            end else begin
                first = CRIT ? (widx % LW) : 0;
                for (int k = 0; k < LW; k++)
                    exp_q.push_back({1'b0, 4'hF, 32'(line * LW * 4 + 4 * ((first + k) % LW))});
                ref_valid = 1'b1;
                ref_line  = line;
                exp_lat   = MISS_LAT;
                exp_n     = LW;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input bit clear,
                         output logic [31:0] rdat, output int lat, output int ack_c);
        int start;
        if (clear) begin
            log_q.delete();
            cyc_hi  = 0;
            min_gap = 1000;
            max_gap = -1;
        end
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        start = cyc_n;
        lat   = -1;
        ack_c = -1;
        rdat  = '0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (wbs_ack_o) begin
                rdat  = wbs_dat_o;
                ack_c = cyc_n;
                lat   = cyc_n - start;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check("ack_seen", 64'(lat >= 0), 64'd1);
    endtask

    task automatic verify(input string nm, input logic we, input logic [31:0] rdat,
                          input int lat, input int ack_c, input logic [31:0] exp_dat,
                          input int exp_lat, input int exp_n);
        int rel, w;
        logic [36:0] e;
        w = 0;
        while (log_q.size() < exp_n && w < 200) begin
            tick();
            w++;
        end
        tick();
        if (!we) check({nm, " data"}, 64'(rdat), 64'(exp_dat));
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " xfers"}, 64'(log_q.size()), 64'(exp_n));
        foreach (log_q[i]) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({nm, " xfer"}, 64'({log_q[i].we, log_q[i].sel, log_q[i].adr}), 64'(e));
            end
        end
        exp_q.delete();
        if (exp_n == 0) begin
            check({nm, " m_cyc idle"}, 64'(cyc_hi), 64'd0);
        end else if (log_q.size() == exp_n) begin
            rel = (we || CRIT) ? 0 : exp_n - 1;
            check({nm, " ack after m_ack"}, 64'(ack_c - log_q[rel].c), 64'd1);
            if (!we) begin
                check({nm, " min gap"}, 64'(min_gap), 64'd1);
                check({nm, " max gap"}, 64'(max_gap), 64'd1);
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_dat;
        int          exp_lat;
        int          exp_n;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [31:0] rdat, mdat, v;
        int          lat, ack_c, mlat, mn;

        vecs[0] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,          32'h0000_0022, MISS_LAT, LW};
        vecs[1] = '{1'b0, 32'h0000_0018, 4'hF, 32'h0,          32'h0000_0033, HIT_LAT,  0};
        vecs[2] = '{1'b1, 32'h0000_0010, 4'h3, 32'hAAAA_BBBB,  32'h0,         WR_LAT,   1};
        vecs[3] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,          32'h0000_BBBB, HIT_LAT,  0};
        vecs[4] = '{1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678,  32'h0,         WR_LAT,   1};
        vecs[5] = '{1'b0, 32'h0000_001C, 4'hF, 32'h0,          32'h0000_0044, HIT_LAT,  0};

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] <= v;
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[4 + i] = 32'h11 * (i + 1);
            slv_mem[4 + i] <= 32'h11 * (i + 1);
        end
        ref_valid = 1'b0;
        ref_line  = 0;
        min_gap   = 1000;
        max_gap   = -1;

        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        repeat (3) tick();
        check("reset ctrl", 64'({wbs_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}), 64'd0);
        check("reset m_adr", 64'(m_adr_o), 64'd0);
        check("reset data", {wbs_dat_o, m_dat_o}, 64'd0);
        wb_rst_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            model(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, mdat, mlat, mn);
            drive(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 1'b1, rdat, lat, ack_c);
            verify($sformatf("row%0d", i), vecs[i].we, rdat, lat, ack_c,
                   vecs[i].exp_dat, vecs[i].exp_lat, vecs[i].exp_n);
        end

        // Reset in the middle of a line fill.
        log_q.delete();
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h0000_0020;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (log_q.size() >= 2) break;
        end
        check("rst_mid_fill reads before reset", 64'(log_q.size()), 64'd2);
        wb_rst_i = 1'b1;
        #1;
        check("rst_mid_fill ctrl", 64'({wbs_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}), 64'd0);
        check("rst_mid_fill m_adr", 64'(m_adr_o), 64'd0);
        check("rst_mid_fill data", {wbs_dat_o, m_dat_o}, 64'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        tick();
        tick();
        wb_rst_i  = 1'b0;
        ref_valid = 1'b0;
        tick();
        model(1'b0, 32'h0000_0014, 4'hF, 32'h0, mdat, mlat, mn);
        drive(1'b0, 32'h0000_0014, 4'hF, 32'h0, 1'b1, rdat, lat, ack_c);
        verify("post_reset", 1'b0, rdat, lat, ack_c, 32'h0000_0022, MISS_LAT, LW);

`ifdef PREFETCH_CRIT_FIRST_EN
        // Critical word first, then a second read that must wait for the fill.
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i  = 1'b0;
        ref_valid = 1'b0;
        tick();
        model(1'b0, 32'h0000_0018, 4'hF, 32'h0, mdat, mlat, mn);
        drive(1'b0, 32'h0000_0018, 4'hF, 32'h0, 1'b1, rdat, lat, ack_c);
        check("crit data", 64'(rdat), 64'h33);
        check("crit latency", 64'(lat), 64'(DELAYS + 1));
        check("crit early xfers", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) check("crit ack after first m_ack", 64'(ack_c - log_q[0].c), 64'd1);
        tick();
        model(1'b0, 32'h0000_0014, 4'hF, 32'h0, mdat, mlat, mn);
        drive(1'b0, 32'h0000_0014, 4'hF, 32'h0, 1'b0, rdat, lat, ack_c);
        check("stall data", 64'(rdat), 64'h22);
        check("stall xfers", 64'(log_q.size()), 64'(LW));
        if (log_q.size() == LW) check("stall ack after fill", 64'(ack_c - log_q[LW-1].c), 64'd2);
        foreach (log_q[i]) begin
            if (exp_q.size() > 0)
                check("crit order", 64'({log_q[i].we, log_q[i].sel, log_q[i].adr}), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        tick();
`endif

        // Random traffic over eight lines, checked against the model.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [31:0] adr, dat;
            logic [3:0]  sel;
            we  = ($urandom_range(0, 99) < 30);
            adr = 32'($urandom_range(0, 127));
            sel = 4'($urandom_range(1, 15));
            dat = $urandom;
            model(we, adr, sel, dat, mdat, mlat, mn);
            drive(we, adr, sel, dat, 1'b1, rdat, lat, ack_c);
            verify($sformatf("rand%0d", i), we, rdat, lat, ack_c, mdat, mlat, mn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_line_prefetch.md
Name: wb_line_prefetch

Overview:
- Single-line read buffer and write-through stage between the management SoC Wishbone master and the multi-cycle external-memory Wishbone slave (the BRAM block with a fixed DELAYS-cycle ack).
- Read miss: fetches a whole aligned line of LINE_WORDS words from downstream.
- Later reads that hit the line complete in 1 cycle instead of the downstream delay.
- Writes pass straight through to downstream and also update the buffer when they hit.

Parameters:
- LINE_WORDS, 4: words per line; power of 2, range 2..16.
- LW_BITS, 2: log2(LINE_WORDS); must match LINE_WORDS.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- wbs_cyc_i  in  1  upstream cycle
- wbs_stb_i  in  1  upstream strobe
- wbs_we_i  in  1  upstream write enable
- wbs_sel_i  in  4  upstream byte selects
- wbs_adr_i  in  32  upstream byte address
- wbs_dat_i  in  32  upstream write data
- wbs_ack_o  out  1  upstream ack, one-cycle pulse
- wbs_dat_o  out  32  upstream read data, valid while wbs_ack_o=1
- m_cyc_o  out  1  downstream cycle
- m_stb_o  out  1  downstream strobe
- m_we_o  out  1  downstream write enable
- m_sel_o  out  4  downstream byte selects
- m_adr_o  out  32  downstream byte address
- m_dat_o  out  32  downstream write data
- m_ack_i  in  1  downstream ack
- m_dat_i  in  32  downstream read data

Behaviour:
- Clock and reset: clock wb_clk_i; reset wb_rst_i, asynchronous, active-high.
- Reset values: all outputs 0; line valid bit 0; tag 0; state IDLE.
- Storage: line buffer of LINE_WORDS x 32 bits.
  - tag = adr[31:LW_BITS+2]
  - word index = adr[LW_BITS+1:2]
  - adr[1:0] ignored
- Request: cyc&stb=1 in IDLE with wbs_ack_o=0.
  - wbs_ack_o is registered, high for exactly 1 cycle.
  - No re-ack in the cycle after an ack, even if stb is still high.
- States: IDLE, FILL, WRITE, ACK.
- IDLE, read hit (valid && tag match):
  - wbs_dat_o = buffer[index]; ack in the next cycle (latency 1).
  - No downstream activity.
- IDLE, read miss:
  - Latch the line base and the requested index; clear valid; go to FILL.
- FILL:
  - Word k at base + 4k, k = 0..LINE_WORDS-1 in ascending order.
  - Drive m_cyc_o=m_stb_o=1, m_we_o=0, m_sel_o=4'hF; hold until m_ack_i.
  - Capture m_dat_i into buffer[k] on the m_ack_i edge.
  - Drop m_cyc_o/m_stb_o for exactly 1 cycle between words.
  - After the last word: set valid, write tag, go to ACK.
- ACK:
  - wbs_ack_o=1 with the requested word; back to IDLE.
  - Only if upstream cyc&stb is still high. If upstream dropped the request mid-fill, the line still becomes valid but no ack is issued.
- IDLE, write:
  - Go to WRITE; drive m_we_o=1, m_sel_o=wbs_sel_i, m_adr_o=wbs_adr_i, m_dat_o=wbs_dat_i until m_ack_i.
  - On m_ack_i: if hit, merge selected bytes into buffer[index].
  - Ack upstream in the next cycle.
  - Writes never allocate; a write miss leaves valid/tag unchanged.
- Upstream requests arriving outside IDLE stall: no ack until processed from IDLE.
- Downstream interface never has more than one outstanding transfer.
- Reset mid-FILL or mid-WRITE:
  - Immediate abort, valid=0, outputs 0.
  - Partial line discarded.

Optional Feature:
- Macro: PREFETCH_CRIT_FIRST_EN.
- Defined (critical-word-first with early restart):
  - Fill order starts at the requested index and wraps modulo LINE_WORDS.
  - wbs_ack_o pulses in the cycle after the m_ack_i that returns the requested word.
  - The remaining words continue filling; valid is set only after the last word.
  - New upstream requests stall until the fill completes.
- Undefined: ascending fill order; ack only after the full line.

Test Plan (downstream model: exmem with DELAYS=10, i.e. ack on the 10th cycle of stb held, seeded mem[0x10..0x1C] = 0x11,0x22,0x33,0x44):
- Read 0x0000_0014 cold -> four downstream reads at 0x10,0x14,0x18,0x1C, 1-cycle stb gap between each; upstream ack 1 cycle after the 4th m_ack_i (within 46 cycles of request); wbs_dat_o=0x22.
- Follow-up read 0x0000_0018 -> ack the next cycle, data 0x33, m_cyc_o stays 0.
- Write 0x0000_0010, sel=4'b0011, data 0xAAAA_BBBB (hit, mem holds 0x0000_0011) -> one downstream write with sel 0011, upstream ack after m_ack_i; then read 0x10 -> 1-cycle hit returning 0x0000_BBBB.
- Write miss 0x0000_0100 then read 0x0000_001C -> still a hit, data 0x44, no refill.
- Read 0x0000_0020 (miss), assert wb_rst_i after 2nd m_ack_i -> all outputs 0 immediately; post-reset read 0x0000_0014 misses and refills.
- With PREFETCH_CRIT_FIRST_EN, cold read 0x0000_0018 -> fill order 0x18,0x1C,0x10,0x14; upstream ack 1 cycle after first m_ack_i with data 0x33; read 0x14 issued during the fill stalls until fill completes, then hits.
